// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_if
// Description : Bundles the request side (from the effective-address stage
//               and the control FSM) and the memory port of the memory-access
//               stage into one interface.
//               slave  modport : seen by mem_access_ctrl
//               master modport : seen by the driver of the stage (EA stage,
//                                control FSM, memory model)
//   ea_in[15:0], ld_mar, start, rw, data_size, wdata[15:0]  request side
//   mem_rdata[15:0], mem_ready                                memory reply
//   mar_out, mdr_out, busy, done, unaligned, bus_err         status
//   mem_en, mem_we, mem_be[1:0], mem_addr, mem_wdata         memory request
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if;
    logic [15:0] ea_in;
    logic        ld_mar;
    logic        start;
    logic        rw;
    logic        data_size;
    logic [15:0] wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] mar_out;
    logic [15:0] mdr_out;
    logic        busy;
    logic        done;
    logic        unaligned;
    logic        bus_err;
    logic        mem_en;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;

    modport slave (
        input  ea_in, ld_mar, start, rw, data_size, wdata, mem_rdata, mem_ready,
        output mar_out, mdr_out, busy, done, unaligned, bus_err,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output ea_in, ld_mar, start, rw, data_size, wdata, mem_rdata, mem_ready,
        input  mar_out, mdr_out, busy, done, unaligned, bus_err,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Memory-access stage. Latches the effective address into MAR
//               and runs one read or write (word or byte) on the memory port
//               with a ready handshake. Byte loads are sign-extended into
//               MDR. Unaligned word requests and memory time-outs are flagged.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_access_ctrl_if.slave (request, status and memory port)
//   TIMEOUT : max ACCESS cycles with mem_ready low before abort, 0 = never
//   CNT_W   : wait counter width, must hold TIMEOUT
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_access_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = TIMEOUT[CNT_W-1:0];
    localparam bit               TO_EN     = (TIMEOUT != 0);

    state_t           state_q, state_d;
    logic [15:0]      mar_q, mar_d;
    logic [15:0]      mdr_q, mdr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             rw_q, rw_d;
    logic             size_q, size_d;
    logic             unal_q, unal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [15:0]      addr_sel;
    logic [CNT_W-1:0] cnt_inc;
    logic [7:0]       rbyte;

    // Start uses the address arriving this cycle when ld_mar is also high.
    assign addr_sel = bus.ld_mar ? bus.ea_in : mar_q;
    // Saturating increment: the counter never wraps back below TIMEOUT.
    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign rbyte    = mar_q[0] ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            size_q  <= 1'b0;
            unal_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            unal_q  <= unal_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        size_d  = size_q;
        unal_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mar_d   = addr_sel;
                    rw_d    = bus.rw;
                    size_d  = bus.data_size;
                    wdata_d = bus.wdata;
                    if (bus.data_size && addr_sel[0]) begin
                        unal_d = 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = '0;
                    end
                end else if (bus.ld_mar) begin
                    mar_d = bus.ea_in;
                end
            end
            S_ACCESS: begin
                if (bus.mem_ready) begin
                    if (!rw_q) begin
                        mdr_d = size_q ? bus.mem_rdata : {{8{rbyte[7]}}, rbyte};
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (TO_EN && (cnt_inc >= TIMEOUT_C)) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory-port outputs are forced to zero outside ACCESS so that reset
    // removes the request immediately.
    assign bus.mar_out   = mar_q;
    assign bus.mdr_out   = mdr_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.bus_err   = (state_q == S_ERR);
    assign bus.unaligned = unal_q;
    assign bus.mem_en    = (state_q == S_ACCESS);
    assign bus.mem_we    = (state_q == S_ACCESS) && rw_q;
    assign bus.mem_be    = (state_q != S_ACCESS) ? 2'b00 :
                           size_q                ? 2'b11 :
                           mar_q[0]              ? 2'b10 : 2'b01;
    assign bus.mem_addr  = (state_q == S_ACCESS) ? mar_q : 16'h0000;
    assign bus.mem_wdata = (state_q != S_ACCESS) ? 16'h0000 :
                           size_q ? wdata_q : {wdata_q[7:0], wdata_q[7:0]};
endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-access stage directly downstream of the effective-address block.
- Latches the computed effective address into MAR and runs a single read or write transaction on the memory port using a ready handshake.
- Supports word and byte accesses and returns load data in MDR (bytes sign-extended).
- Flags unaligned word accesses and memory time-outs to the control FSM.

Parameters:
- TIMEOUT, 255: max ACCESS cycles with mem_ready low before aborting; 0 disables the time-out.
- CNT_W, 8: width of the wait counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- ea_in  input  16  effective address from EA stage
- ld_mar  input  1  load MAR from ea_in (honoured only in IDLE)
- start  input  1  begin transaction (honoured only in IDLE)
- rw  input  1  1 = write, 0 = read; sampled with start
- data_size  input  1  1 = word, 0 = byte; sampled with start
- wdata  input  16  store data; sampled with start
- mem_rdata  input  16  memory read data
- mem_ready  input  1  memory completes the current access this cycle
- mar_out  output  16  current MAR value
- mdr_out  output  16  load data register
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse, transaction complete
- unaligned  output  1  one-cycle pulse, word access to odd address rejected
- bus_err  output  1  one-cycle pulse, time-out abort
- mem_en  output  1  memory request
- mem_we  output  1  write strobe
- mem_be  output  2  byte enables, [1] = high byte
- mem_addr  output  16  memory address
- mem_wdata  output  16  memory write data

Behaviour:
Reset (async, immediate):
- State = IDLE.
- MAR = 0, MDR = 0, wait counter = 0.
- All outputs 0, including mem_en mid-transaction.
- No partial completion is signalled after reset releases.

States: IDLE, ACCESS, DONE, ERR.

IDLE:
- ld_mar=1: MAR <= ea_in.
- start=1 uses the effective address A = ea_in if ld_mar is also high this cycle, else MAR. A is latched into MAR.
- rw, data_size and wdata are latched with start.
- If data_size=1 and A[0]=1: unaligned=1 next cycle, stay IDLE, no memory request.
- Otherwise go to ACCESS.

ACCESS:
- mem_en=1 and mem_addr = MAR.
- mem_we = latched rw.
- mem_be: word -> 2'b11; byte -> MAR[0] ? 2'b10 : 2'b01.
- mem_wdata: word -> wdata; byte -> {wdata[7:0], wdata[7:0]}.
- mem_ready sampled every ACCESS cycle, including the first.
- On mem_ready=1 for a read:
  - word: MDR <= mem_rdata.
  - byte: MDR <= sign-extended mem_rdata[15:8] if MAR[0]=1, else sign-extended mem_rdata[7:0].
  - Then go to DONE.
- On mem_ready=1 for a write: MDR unchanged; go to DONE.
- On mem_ready=0: increment the wait counter. If TIMEOUT != 0 and the counter reaches TIMEOUT, go to ERR.

DONE:
- done=1 for one cycle, mem_en=0; then IDLE. MDR is valid from this cycle.

ERR:
- bus_err=1 for one cycle, mem_en=0, MDR unchanged; then IDLE.

Wait counter:
- Cleared on entry to ACCESS. Saturates; it never wraps.

Timing:
- Latency: start sampled at edge 0 -> ACCESS from cycle 1. If mem_ready is first high in ACCESS cycle k (k >= 1), done is high in cycle k+1.
- Minimum transaction is 3 cycles, start to back in IDLE.

While busy:
- start and ld_mar are ignored.
- MAR, rw, size and wdata are held.
- mem_ready outside ACCESS is ignored.

Outputs:
- busy = (state != IDLE).
- mar_out always reflects MAR.

Test Plan:
- Word read: ld_mar with ea_in=0x3000, then start rw=0 size=1, memory returns 0xBEEF with mem_ready after 2 wait cycles -> mem_be=11, mem_addr=0x3000, done in cycle 4, mdr_out=0xBEEF, busy low in cycle 5.
- Byte loads: read at 0x3001 with mem_rdata=0x80FF -> mem_be=10, mdr_out=0xFF80. Read at 0x3000 with the same data -> mem_be=01, mdr_out=0xFFFF.
- Byte store: MAR=0x4001, wdata=0x1234, rw=1, size=0 -> mem_we=1, mem_be=10, mem_wdata=0x3434, done pulse, MDR unchanged.
- Unaligned: start size=1 with ea_in=0x2005 and ld_mar=1 in the same cycle -> MAR=0x2005, unaligned pulse next cycle, mem_en never asserted, busy stays 0.
- Time-out: TIMEOUT=4, mem_ready held low -> 4 ACCESS cycles then bus_err pulse, back to IDLE, MDR unchanged. A new start while busy is ignored.
- Async reset mid-access: assert rst during ACCESS, between clock edges -> mem_en, busy and mar_out drop to 0 immediately. After release there is no done or bus_err pulse, and the next transaction works normally.
